// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial word receiver with cClk-domain synchronisers
//
// Receives words from an asynchronous serial link (dClk, data, sync) and
// presents each completed word with valid/ready handshaking.
//
// Parameters
//   WORD_W          bits per data word (2..32)
//   WORDS_PER_FRAME words expected after each frame marker (1..256)
//   MSB_FIRST       0: first received bit lands in bit 0; 1: in bit WORD_W-1
//
// Ports
//   cClk        in   common clock, all logic on its rising edge
//   reset       in   synchronous active-high reset
//   dClk        in   asynchronous bit clock, data is taken at its falling edge
//   data        in   asynchronous serial data
//   sync        in   asynchronous frame marker, rising edge starts a frame
//   word_out    out  last completed word
//   word_idx    out  index of word_out within its frame
//   word_valid  out  word_out/word_idx hold an unaccepted word
//   word_ready  in   consumer accepts when word_valid & word_ready
//   frame_done  out  one-cycle pulse when the last word of a frame completes
//   overrun     out  sticky, an unaccepted word was overwritten
//   parity_err  out  sticky, odd-parity failure (tied 0 without parity)
//
// Build option
//   RX_PARITY_EN  each word is followed by one odd-parity bit
module serial_frame_rx #(
    parameter int WORD_W = 16,
    parameter int WORDS_PER_FRAME = 8,
    parameter int MSB_FIRST = 0,
    localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  logic              cClk,
    input  logic              reset,
    input  logic              dClk,
    input  logic              data,
    input  logic              sync,
    output logic [WORD_W-1:0] word_out,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_done,
    output logic              overrun,
    output logic              parity_err
);

`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = WORD_W + 1;
`else
    localparam int FRAME_BITS = WORD_W;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t            state;
    logic [2:0]        dClkSync;
    logic [2:0]        syncSync;
    logic [2:0]        dataSync;
    logic [CNT_W-1:0]  bitCnt;
    logic [IDX_W-1:0]  wordCnt;
    logic [WORD_W-1:0] shiftReg;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] nextWord;
    logic              syncFront;
    logic              clkRear;
    logic              bitIn;
    logic              lastBit;
    logic              lastWord;
`ifdef RX_PARITY_EN
    logic              parityAcc;
    logic              nextParity;
`endif

    // index 0 is the first synchroniser stage, index 2 the third
    assign syncFront = syncSync[1] & ~syncSync[2];
    assign clkRear   = dClkSync[2] & ~dClkSync[1];
    assign bitIn     = dataSync[2];
    assign lastBit   = bitCnt == CNT_W'(FRAME_BITS - 1);
    assign lastWord  = wordCnt == IDX_W'(WORDS_PER_FRAME - 1);

    // after WORD_W shifts every stale bit has left the register, so a
    // discarded partial word never needs explicit clearing
    always_comb begin
        shifted = (MSB_FIRST != 0) ? {shiftReg[WORD_W-2:0], bitIn} : {bitIn, shiftReg[WORD_W-1:1]};
`ifdef RX_PARITY_EN
        nextWord   = (bitCnt == CNT_W'(WORD_W)) ? shiftReg : shifted;
        nextParity = parityAcc ^ bitIn;
`else
        nextWord = shifted;
`endif
    end

`ifndef RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge cClk) begin
        if (reset) begin
            state      <= HUNT;
            dClkSync   <= '0;
            syncSync   <= '0;
            dataSync   <= '0;
            bitCnt     <= '0;
            wordCnt    <= '0;
            shiftReg   <= '0;
            word_out   <= '0;
            word_idx   <= '0;
            word_valid <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
`ifdef RX_PARITY_EN
            parityAcc  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            dClkSync   <= {dClkSync[1:0], dClk};
            syncSync   <= {syncSync[1:0], sync};
            dataSync   <= {dataSync[1:0], data};
            frame_done <= 1'b0;
            if (word_valid && word_ready)
                word_valid <= 1'b0;
            // a marker wins over a coincident bit, which is dropped
            if (syncFront) begin
                state   <= RECV;
                bitCnt  <= '0;
                wordCnt <= '0;
                overrun <= 1'b0;
`ifdef RX_PARITY_EN
                parityAcc  <= 1'b0;
                parity_err <= 1'b0;
`endif
            end else if (state == RECV && clkRear) begin
                shiftReg <= nextWord;
                bitCnt   <= bitCnt + 1'b1;
`ifdef RX_PARITY_EN
                parityAcc <= nextParity;
`endif
                if (lastBit) begin
                    word_out   <= nextWord;
                    word_idx   <= wordCnt;
                    word_valid <= 1'b1;
                    // a word accepted this very cycle is not lost
                    if (word_valid && !word_ready)
                        overrun <= 1'b1;
`ifdef RX_PARITY_EN
                    parityAcc <= 1'b0;
                    if (!nextParity)
                        parity_err <= 1'b1;
`endif
                    bitCnt  <= '0;
                    wordCnt <= lastWord ? '0 : wordCnt + 1'b1;
                    if (lastWord) begin
                        frame_done <= 1'b1;
                        state      <= HUNT;
                    end
                end
            end
        end
    end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter WORD_W, default 16, bits per data word (range 2..32).
REQ-002 SHALL have parameter WORDS_PER_FRAME, default 8, words expected after each frame marker (range 1..256).
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = first received bit lands in bit 0, 1 = first received bit lands in bit WORD_W-1.
REQ-004 SHALL have port cClk, input, 1, common clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port dClk, input, 1, asynchronous incoming bit clock.
REQ-007 SHALL have port data, input, 1, asynchronous serial data; valid at the dClk falling edge.
REQ-008 SHALL have port sync, input, 1, asynchronous frame marker; its rising edge starts a frame.
REQ-009 SHALL have port word_out, output, WORD_W, last completed word.
REQ-010 SHALL have port word_idx, output, max(1,clog2(WORDS_PER_FRAME)), index of word_out within its frame.
REQ-011 SHALL have port word_valid, output, 1, word_out/word_idx hold an unaccepted word.
REQ-012 SHALL have port word_ready, input, 1, consumer accepts the word when word_valid and word_ready are both 1.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when the final word of a frame completes.
REQ-014 SHALL have port overrun, output, 1, sticky flag: a word was lost.
REQ-015 SHALL have port parity_err, output, 1, sticky flag: parity failure (see Configuration).

Function
REQ-016 SHALL pass dClk, sync and data each through a 3-stage cClk shift register; syncFront = stage2 & !stage3 of sync; clkRear = stage3 & !stage2 of dClk; the data bit is sampled from stage 3 of data.
REQ-017 SHALL implement FSM states HUNT and RECV; reset enters HUNT.
REQ-018 In HUNT, clkRear SHALL be ignored; syncFront SHALL clear the bit and word counters and enter RECV.
REQ-019 In RECV, each clkRear SHALL place the sampled bit into the shift register at the position given by MSB_FIRST and increment the bit counter.
REQ-020 When the bit counter reaches the frame-bit count (WORD_W, or WORD_W+1 with parity), the word SHALL be loaded into word_out and word_idx on the next cClk with word_valid=1. Latency: 1 cClk after the clkRear cycle of the last bit.
REQ-021 On word completion, the bit counter SHALL clear and the word counter SHALL increment.
REQ-022 On completion of word WORDS_PER_FRAME-1, frame_done SHALL pulse in the same cycle word_valid rises, and the FSM SHALL return to HUNT.
REQ-023 A syncFront in RECV SHALL discard any partial word, clear both counters and stay in RECV.
REQ-024 If syncFront and clkRear occur in the same cycle, syncFront SHALL win and that bit SHALL be dropped.
REQ-025 word_valid SHALL stay 1 and word_out/word_idx SHALL stay stable until accepted.
REQ-026 If a word completes while word_valid=1 and word_ready=0, the new word SHALL overwrite the held word and overrun SHALL be set.
REQ-027 If a word completes in the same cycle the held word is accepted, the new word SHALL load, word_valid SHALL stay 1, and overrun SHALL stay unchanged.
REQ-028 overrun and parity_err SHALL clear only on reset or syncFront.

Reset
REQ-029 When reset=1 at a cClk edge, the following SHALL apply: all synchroniser stages 0; word_out 0; word_idx 0; word_valid 0; frame_done 0; overrun 0; parity_err 0; counters 0; FSM in HUNT.
REQ-030 Reset mid-frame SHALL abandon the frame; reception resumes only after a later syncFront.

Configuration
REQ-031 Macro RX_PARITY_EN defined: each word SHALL be followed by one odd-parity bit (WORD_W+1 bits per word), and the parity bit SHALL not appear in word_out. A mismatch SHALL set parity_err, and the word SHALL still be delivered.
REQ-032 Macro RX_PARITY_EN undefined: words SHALL be WORD_W bits, and parity_err SHALL be tied to 0.

Verification
REQ-033 Defaults, no parity: sync rise, then 16 bits of 0xA5C3 LSB-first with word_ready=1 -> word_out=0xA5C3, word_idx=0, and word_valid high for 1 cycle.
REQ-034 WORDS_PER_FRAME=2, MSB_FIRST=1: sync, then 0x1234 and 0xBEEF sent MSB-first -> idx 0 gives 0x1234; idx 1 gives 0xBEEF with frame_done pulse; extra dClk edges afterwards produce no output.
REQ-035 word_ready=0: two words 0x0001 and 0x0002 complete -> word_out=0x0002, overrun=1; next sync rise -> overrun=0.
REQ-036 sync rise after 7 bits of a word, then a full word 0x00FF -> word_out=0x00FF, word_idx=0; the partial word is never presented.
REQ-037 RX_PARITY_EN: 0x0003 followed by parity bit 0 -> parity_err=1 and word delivered; 0x0003 followed by parity bit 1 -> parity_err=0.
REQ-038 reset asserted for 1 cycle mid-word -> all outputs 0, FSM in HUNT; following dClk edges without sync produce no word_valid.
